// File: rtl/fb_pkg.sv
// Shared framebuffer constants and types for the scanout path.
package fb_pkg;

    localparam int H_RES    = 800;
    localparam int V_RES    = 480;
    localparam int FB_DEPTH = H_RES * V_RES;
    localparam int FB_ADDRW = $clog2(FB_DEPTH);
    localparam int PIX_W    = 4;

    // Palette stage maps this index to background; scanout passes it through.
    localparam logic [PIX_W-1:0] TRANSPARENT_IDX = 4'hF;

    typedef enum logic {
        IDLE,
        PENDING
    } swap_state_t;

endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with synchronous reset; used to align
// control/sync bits with the framebuffer read pipeline.
module delay_line
    import fb_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_q;

    // Shift one stage per clock; reset flushes every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: issues BRAM reads ahead of the beam, returns colour
// indices aligned with delayed de/hsync/vsync, and swaps front/back buffers
// at the start of vblank when the renderer asks.
module fb_scanout #(
    parameter int CORDW  = 10,
    parameter int H_RES  = fb_pkg::H_RES,
    parameter int V_RES  = fb_pkg::V_RES,
    parameter int PIX_W  = fb_pkg::PIX_W,
    parameter int PACKED = 0,
    parameter int RD_LAT = 1,
    parameter int ADDRW  = 19
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [CORDW-1:0]            sx,
    input  logic [CORDW-1:0]            sy,
    input  logic                        de,
    input  logic                        hsync,
    input  logic                        vsync,
    input  logic                        swap_req,
    output logic [ADDRW-1:0]            fb_addr,
    output logic                        fb_en,
    output logic                        fb_sel,
    input  logic [PIX_W*(PACKED+1)-1:0] fb_rdata,
    output logic                        swap_ack,
    output logic [PIX_W-1:0]            pix,
    output logic                        de_o,
    output logic                        hsync_o,
    output logic                        vsync_o
);
    import fb_pkg::*;

    localparam int L   = RD_LAT + 2;
    localparam int AW1 = ADDRW + 1;
    localparam logic [CORDW-1:0] H_RES_C = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_RES_C = CORDW'(V_RES);

    // ---------------- stage A: address generation ----------------
    logic           act;
    logic [AW1-1:0] lin;
    logic [AW1-1:0] word;
    logic [ADDRW-1:0] fb_addr_q, fb_addr_d;
    logic             fb_en_q, fb_en_d;

    assign act  = de && (sx < H_RES_C) && (sy < V_RES_C);
    assign lin  = AW1'(sx) + AW1'(sy) * AW1'(H_RES);
    assign word = (PACKED != 0) ? (lin >> 1) : lin;

    // Next read address: follow the beam while active, otherwise hold.
    always_comb begin
        fb_en_d   = act;
        fb_addr_d = fb_addr_q;
        if (act) fb_addr_d = word[ADDRW-1:0];
    end

    // Stage A register.
    always_ff @(posedge clk) begin
        if (rst) begin
            fb_addr_q <= '0;
            fb_en_q   <= 1'b0;
        end else begin
            fb_addr_q <= fb_addr_d;
            fb_en_q   <= fb_en_d;
        end
    end

    assign fb_addr = fb_addr_q;
    assign fb_en   = fb_en_q;

    // ---------------- alignment delay lines ----------------
    logic act_d, odd_d;

    // act and pixel parity arrive together with fb_rdata.
    delay_line #(.WIDTH(2), .DEPTH(L-1)) u_act_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({act, sx[0]}),
        .q_o ({act_d, odd_d})
    );

    // Sync signals see the full pipeline latency.
    delay_line #(.WIDTH(3), .DEPTH(L)) u_sync_dly (
        .clk (clk),
        .rst (rst),
        .d_i ({de, hsync, vsync}),
        .q_o ({de_o, hsync_o, vsync_o})
    );

    // ---------------- stage B: pixel select ----------------
    logic [PIX_W-1:0] nib;
    logic [PIX_W-1:0] pix_q, pix_d;

    generate
        if (PACKED != 0) begin : g_packed
            assign nib = odd_d ? fb_rdata[2*PIX_W-1:PIX_W] : fb_rdata[PIX_W-1:0];
        end else begin : g_flat
            assign nib = fb_rdata;
        end
    endgenerate

    // Blank pixels are forced to index 0; index 15 is not special here.
    always_comb begin
        pix_d = '0;
        if (act_d) pix_d = nib;
    end

    // Stage B register.
    always_ff @(posedge clk) begin
        if (rst) pix_q <= '0;
        else     pix_q <= pix_d;
    end

    assign pix = pix_q;

    // ---------------- buffer swap FSM ----------------
    swap_state_t state_q, state_d;
    logic        boundary, toggle;
    logic        fb_sel_q, fb_sel_d;
    logic        swap_ack_q, swap_ack_d;

    // First pixel slot of the first vblank line; no active pixel is in flight.
    assign boundary = (sx == '0) && (sy == V_RES_C);

    // Next-state: latch a request, toggle once at the next boundary.
    always_comb begin
        state_d    = state_q;
        toggle     = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req) begin
                    if (boundary) toggle  = 1'b1;
                    else          state_d = PENDING;
                end
            end
            PENDING: begin
                if (boundary) begin
                    toggle  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        fb_sel_d   = fb_sel_q ^ toggle;
        swap_ack_d = toggle;
    end

    // Swap state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fb_sel_q   <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fb_sel_q   <= fb_sel_d;
            swap_ack_q <= swap_ack_d;
        end
    end

    assign fb_sel   = fb_sel_q;
    assign swap_ack = swap_ack_q;

    // Bits that only matter for some parameter settings.
    logic unused_bits;
    assign unused_bits = ^{word[ADDRW], odd_d};

endmodule

// File: doc/fb_scanout.md
Name: fb_scanout

Overview:
- Read side of the sprite framebuffer. The sprite renderer writes 4-bit colour indices into framebuffer BRAM; this block reads them back in raster order for the display.
- It is driven by the display timing generator (sx, sy, de, hsync, vsync) and issues BRAM read addresses ahead of the beam.
- It emits pixel indices with sync/de delayed to match, ready for the palette stage.
- It owns front/back buffer selection and swaps at vblank on request from the render controller.

Parameters:
- CORDW, 10, screen coordinate width.
- H_RES, 800, active pixels per line; also the framebuffer row stride.
- V_RES, 480, active lines.
- PIX_W, 4, colour index width.
- PACKED, 0: 0 = one pixel per word; 1 = two pixels per 8-bit word, even pixel in bits [3:0].
- RD_LAT, 1, framebuffer BRAM read latency in cycles (1..3).
- ADDRW, 19, framebuffer address width.

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous reset, active-high
- sx  in  CORDW  timing-generator x
- sy  in  CORDW  timing-generator y
- de  in  1  data enable from timing generator
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- swap_req  in  1  single-cycle pulse: back buffer complete, swap at next vblank
- fb_addr  out  ADDRW  in-buffer read address
- fb_en  out  1  BRAM read enable
- fb_sel  out  1  current front buffer; back buffer = !fb_sel
- fb_rdata  in  PIX_W*(PACKED+1)  BRAM read data
- swap_ack  out  1  single-cycle pulse when fb_sel toggles
- pix  out  PIX_W  colour index; 0 when de_o low
- de_o  out  1  delayed de
- hsync_o  out  1  delayed hsync
- vsync_o  out  1  delayed vsync

Behaviour:
- Reset: fb_addr=0, fb_en=0, fb_sel=0, swap_ack=0, pix=0, de_o=0, hsync_o=0, vsync_o=0, swap_pending=0, all delay stages=0.
- Reset mid-frame takes effect on the next clk edge and clears every pipeline stage. No stale pixel may emerge after reset.
- Active qualification: act = de && sx < H_RES && sy < V_RES. If de is high outside that range, the pixel is treated as blank.
- Stage A (registered, cycle t+1):
  - PACKED=0: fb_addr = sx + sy*H_RES.
  - PACKED=1: fb_addr = (sx + sy*H_RES) >> 1.
  - Arithmetic is done at ADDRW+1 bits. Maximum index is 383999, which fits in 19 bits.
  - fb_en = act. When act=0, fb_addr holds its previous value.
- fb_rdata is valid RD_LAT cycles after fb_en.
- Stage B (registered, cycle t+2+RD_LAT):
  - pix = selected nibble when the delayed act is high, else 0.
  - For PACKED=1 the nibble select is the delayed sx[0]: 0 selects bits [3:0], 1 selects bits [7:4].
- Total latency L = RD_LAT+2. de_o, hsync_o and vsync_o equal de, hsync and vsync delayed by exactly L cycles, with no glitching across line or frame wrap.
- Index 15 (transparent) is passed through unchanged. The palette stage maps it to background.
- Buffer swap FSM, two states, IDLE and PENDING:
  - IDLE to PENDING on swap_req.
  - PENDING to IDLE at the frame boundary, defined as sx==0 && sy==V_RES (first vblank line) on a clk edge with stage-A input. At that edge fb_sel toggles and swap_ack pulses for 1 cycle.
  - If swap_req coincides with the boundary cycle (in IDLE or PENDING), the swap happens at that boundary.
  - swap_req while PENDING is absorbed: exactly one toggle per boundary.
  - No boundary is seen: remain PENDING indefinitely.
- fb_sel never changes while any active pixel is in flight. The boundary is in vblank and L < H blanking.

Decomposition:
- Package fb_pkg holds:
  - H_RES, V_RES, FB_DEPTH = H_RES*V_RES, FB_ADDRW, PIX_W.
  - TRANSPARENT_IDX = 4'hF.
  - typedef swap_state_t enum {IDLE, PENDING}.
- Sub-module delay_line (parameters WIDTH, DEPTH; synchronous-reset shift register). Instantiated for {act, sx[0]} (depth L-1) and {de, hsync, vsync} (depth L).

Test Plan:
- Addressing: RD_LAT=1, PACKED=0; fb model returns addr[3:0]. At sx=5, sy=2, de=1: fb_addr=1605 one cycle later, pix=4'h5 three cycles after input, de_o high in that same cycle.
- Packed and blanking: PACKED=1, word at addr 800 = 8'hA3. Drive sx=0 then sx=1 on sy=2: fb_addr=800 twice, pix=3 then A. Drive sx=820, de=1: fb_en=0, pix=0.
- Swap: pulse swap_req at sy=100, then run to sy=480, sx=0: fb_sel goes 0->1 with a 1-cycle swap_ack. Pulse swap_req 3 times mid-frame: exactly one toggle. No swap_req for a whole frame: fb_sel unchanged.
- Coincident swap: swap_req on the boundary cycle itself -> toggle on that cycle.
- Reset mid-line: assert rst at sx=400, sy=10, release 1 cycle later. pix, de_o and fb_en are 0 for L cycles, fb_sel=0, and valid output resumes L cycles after the next active input.
- Sync alignment: RD_LAT=3 over a full frame. hsync_o, vsync_o and de_o match the inputs delayed by 5 cycles on every cycle, including line and frame wrap.
